ws2812_enc: RTL and testbench

WS2812_ENC -- requirements
Module: ws2812_enc

---
 rtl/ws2812_enc.sv | 144 ++++++++++++++
 tb/tb_ws2812_enc.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_enc.sv
// WS2812 single-wire bit encoder: turns strobed data bits into timed high/low pulses,
// with a one-deep pending slot so a host can stream bits back-to-back without gaps.
`timescale 1ns/1ps

module ws2812_enc #(
    parameter logic [15:0] CNT_T0H    = 16'd80,
    parameter logic [15:0] CNT_T1H    = 16'd160,
    parameter logic [15:0] CNT_PERIOD = 16'd250,
    parameter logic [15:0] DONE_LEAD  = 16'd4
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic bit_rdy_in,
    input  logic bit_data_in,
    output logic bit_done_out,
    output logic busy_out,
    output logic ovf_out,
    output logic ws2812_data_out
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_PERIOD - CNT_W'(1);
    localparam logic [CNT_W-1:0] DONE_CNT = CNT_PERIOD - CNT_W'(1) - DONE_LEAD;

    if (!((CNT_T0H > 16'd0) && (CNT_T0H < CNT_T1H) &&
          (CNT_T1H < CNT_PERIOD - DONE_LEAD - 16'd1))) begin : g_param_err
        $error("ws2812_enc: illegal timing parameters (need 0 < T0H < T1H < PERIOD-DONE_LEAD-1)");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cur_q, cur_d;
    logic               pend_vld_q, pend_vld_d;
    logic               pend_data_q, pend_data_d;
    logic               data_q, data_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   thigh_c;
    logic               last_c;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cur_q       <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_data_q <= 1'b0;
            data_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_q       <= cur_d;
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
            data_q      <= data_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_d       = cur_q;
        pend_vld_d  = pend_vld_q;
        pend_data_d = pend_data_q;
        ovf_d       = ovf_q;
        thigh_c     = cur_q ? CNT_T1H : CNT_T0H;
        last_c      = (state_q == LOW) && (cnt_q == LAST_CNT);

        case (state_q)
            IDLE: begin
                if (bit_rdy_in) begin
                    cur_d   = bit_data_in;
                    cnt_d   = '0;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == thigh_c - CNT_W'(1)) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                if (last_c) begin
                    cnt_d = '0;
                    if (pend_vld_q) begin
                        cur_d      = pend_data_q;
                        state_d    = HIGH;
                        pend_vld_d = 1'b0;
                    end else if (bit_rdy_in) begin
                        cur_d   = bit_data_in;
                        state_d = HIGH;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Strobes during a bit go to the pending slot; on the last cycle a consumed slot refills.
        if ((state_q != IDLE) && bit_rdy_in) begin
            if (!pend_vld_q) begin
                if (!last_c) begin
                    pend_vld_d  = 1'b1;
                    pend_data_d = bit_data_in;
                end
            end else if (last_c) begin
                pend_vld_d  = 1'b1;
                pend_data_d = bit_data_in;
            end else begin
                ovf_d = 1'b1;
            end
        end

        data_d = (state_d == HIGH);
        busy_d = (state_d != IDLE);
        done_d = (state_d == LOW) && (cnt_d == DONE_CNT);
    end

    assign ws2812_data_out = data_q;
    assign bit_done_out    = done_q;
    assign busy_out        = busy_q;
    assign ovf_out         = ovf_q;

endmodule

// File: tb/tb_ws2812_enc.sv
// Directed bench for ws2812_enc at default timing: table of single bits plus
// streaming, last-cycle strobe, overflow and mid-bit reset sequences.
`timescale 1ns/1ps

module tb_ws2812_enc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b0;
    logic din = 1'b0;
    logic done, busy, ovf, dout;

    always #5 clk = ~clk;

    ws2812_enc dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .bit_rdy_in      (rdy),
        .bit_data_in     (din),
        .bit_done_out    (done),
        .busy_out        (busy),
        .ovf_out         (ovf),
        .ws2812_data_out (dout)
    );

    typedef struct {
        logic d;
        int   hi;
        int   lo;
        int   done_k;
        int   idle_k;
        logic ovf;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Line monitor: high/low run length per bit, done pulses and busy cycles.
    int hi_run = 0;
    int lo_run = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int hi_q[$];
    int lo_q[$];

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if (dout) begin
            if (lo_run > 0) begin
                hi_q.push_back(hi_run);
                lo_q.push_back(lo_run);
                hi_run = 0;
                lo_run = 0;
            end
            hi_run++;
        end else if (busy) begin
            lo_run++;
        end else if (hi_run > 0) begin
            hi_q.push_back(hi_run);
            lo_q.push_back(lo_run);
            hi_run = 0;
            lo_run = 0;
        end
    end

    function automatic int get_hi(input int idx);
        return (idx < hi_q.size()) ? hi_q[idx] : -1;
    endfunction

    function automatic int get_lo(input int idx);
        return (idx < lo_q.size()) ? lo_q[idx] : -1;
    endfunction

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at posedge+1; strobe is sampled on the next rising edge.
    task automatic pulse(input logic d);
        rdy = 1'b1;
        din = d;
        @(posedge clk);
        #1;
        rdy = 1'b0;
        din = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, seen, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, seen, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        int   base;
        int   d0;
        int   k_done;
        int   k_idle;
        logic first;
        base   = hi_q.size();
        d0     = done_cnt;
        k_done = -1;
        k_idle = -1;
        first  = 1'b0;
        pulse(v.d);
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (k == 1) first = dout;
            if (done && (k_done < 0)) k_done = k;
            if (!busy) begin
                k_idle = k;
                break;
            end
        end
        @(posedge clk);
        #1;
        check({tag, "_rise"}, first, 1);
        check({tag, "_done_at"}, k_done, v.done_k);
        check({tag, "_idle_at"}, k_idle, v.idle_k);
        check({tag, "_high"}, get_hi(base), v.hi);
        check({tag, "_low"}, get_lo(base), v.lo);
        check({tag, "_done_cnt"}, done_cnt - d0, 1);
        check({tag, "_ovf"}, ovf, v.ovf);
    endtask

    vec_t vecs[3];

    initial begin
        int          base;
        int          d0;
        int          b0;
        logic [23:0] pat;
        int          exp_hi;

        // Strobe sampled at edge P: done in cycle cnt=245 (k=246), idle at k=251.
        vecs[0] = '{d: 1'b1, hi: 160, lo: 90,  done_k: 246, idle_k: 251, ovf: 1'b0};
        vecs[1] = '{d: 1'b0, hi: 80,  lo: 170, done_k: 246, idle_k: 251, ovf: 1'b0};
        vecs[2] = '{d: 1'b1, hi: 160, lo: 90,  done_k: 246, idle_k: 251, ovf: 1'b0};

        #2;
        check("rst_dout", dout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // 24-bit stream, each bit_done answered by a strobe two cycles later.
        pat  = 24'hA5C3F0;
        base = hi_q.size();
        d0   = done_cnt;
        b0   = busy_cnt;
        pulse(pat[23]);
        for (int i = 22; i >= 0; i--) begin
            wait_done("stream_done_wait");
            pulse(pat[i]);
        end
        wait_idle("stream_idle_wait");
        check("stream_bits", hi_q.size() - base, 24);
        for (int i = 0; i < 24; i++) begin
            exp_hi = pat[23 - i] ? 160 : 80;
            check($sformatf("stream_high%0d", i), get_hi(base + i), exp_hi);
            check($sformatf("stream_period%0d", i), get_hi(base + i) + get_lo(base + i), 250);
        end
        check("stream_done_cnt", done_cnt - d0, 24);
        check("stream_busy_cycles", busy_cnt - b0, 6000);

        // Strobe on the final LOW cycle with an empty pending slot.
        base = hi_q.size();
        d0   = done_cnt;
        b0   = busy_cnt;
        pulse(1'b1);
        repeat (249) @(posedge clk);
        #1;
        pulse(1'b0);
        wait_idle("last_idle_wait");
        check("last_bits", hi_q.size() - base, 2);
        check("last_high0", get_hi(base), 160);
        check("last_low0", get_lo(base), 90);
        check("last_high1", get_hi(base + 1), 80);
        check("last_low1", get_lo(base + 1), 170);
        check("last_busy_cycles", busy_cnt - b0, 500);
        check("last_done_cnt", done_cnt - d0, 2);

        // Three strobes in one bit: second pends, third overflows.
        base = hi_q.size();
        d0   = done_cnt;
        b0   = busy_cnt;
        pulse(1'b1);
        repeat (10) @(posedge clk);
        #1;
        pulse(1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("ovf_before", ovf, 0);
        pulse(1'b1);
        @(negedge clk);
        check("ovf_set", ovf, 1);
        @(posedge clk);
        #1;
        wait_idle("ovf_idle_wait");
        check("ovf_bits", hi_q.size() - base, 2);
        check("ovf_high0", get_hi(base), 160);
        check("ovf_low0", get_lo(base), 90);
        check("ovf_high1", get_hi(base + 1), 80);
        check("ovf_low1", get_lo(base + 1), 170);
        check("ovf_busy_cycles", busy_cnt - b0, 500);
        check("ovf_done_cnt", done_cnt - d0, 2);
        check("ovf_sticky", ovf, 1);

        // Reset in cycle cnt=50 of a 1 bit.
        d0 = done_cnt;
        pulse(1'b1);
        repeat (50) @(posedge clk);
        #1;
        check("midrst_pre_dout", dout, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_dout", dout, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ovf", ovf, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_idle", busy, 0);
        apply_vec(vecs[0], "postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
